led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arbiter.sv | 97 +++++++++
 tb/tb_led_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// Round-robin owner of one 8-bit LED bank shared by four clients, with a time-slice limit while others wait.
// grant and led are registered, so one cycle from req/data to outputs; no backpressure, and a waiting client just keeps req high.
module led_arbiter #(
  parameter int unsigned SLICE_CYCLES = 1024,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  grant,
  output logic [7:0]  led,
  output logic        busy
);

  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  OWN     = 1'b1;
  localparam logic [15:0] CNT_MAX = 16'(SLICE_CYCLES - 1);

  logic [0:0]  state;
  logic [1:0]  last;
  logic [15:0] cnt;

  logic [1:0]  win;
  logic        win_vld;
  logic [1:0]  idx;
  logic        others_vld;
  logic        do_switch;
  logic        do_idle;
  logic [7:0]  win_dat;
  logic [7:0]  own_dat;

  // The owner sits in last, so searching from last+1 puts it at the lowest priority.
  always_comb begin
    win     = last;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign others_vld = |(req & ~(4'b0001 << last));
  assign win_dat    = data[{win, 3'b000} +: 8];
  assign own_dat    = data[{last, 3'b000} +: 8];

  always_comb begin
    do_switch = 1'b0;
    do_idle   = 1'b0;
    case (state)
      IDLE: do_switch = win_vld;
      OWN: begin
        if (!req[last]) begin
          do_switch = win_vld;
          do_idle   = !win_vld;
        end else begin
          do_switch = (cnt == CNT_MAX) && others_vld;
        end
      end
      default: do_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 2'd3;
      cnt   <= '0;
      grant <= '0;
      led   <= IDLE_PATTERN;
    end else if (do_switch) begin
      state <= OWN;
      last  <= win;
      cnt   <= '0;
      grant <= 4'b0001 << win;
      led   <= win_dat;
    end else if (state == IDLE || do_idle) begin
      state <= IDLE;
      cnt   <= '0;
      grant <= '0;
      led   <= IDLE_PATTERN;
    end else begin
      // Saturate rather than wrap so a lone owner is preempted on the first competing edge.
      led <= own_dat;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: vector table through a scoreboard, plus reset and long-slice sequences.
module tb_led_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;
  logic [3:0]  big_grant;
  logic [7:0]  big_led;
  logic        big_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_arbiter #(.SLICE_CYCLES(4), .IDLE_PATTERN(8'hC3)) u_dut (
    .clk(clk), .resetn(resetn), .req(req), .data(data),
    .grant(grant), .led(led), .busy(busy)
  );

  led_arbiter u_big (
    .clk(clk), .resetn(resetn), .req(req), .data(data),
    .grant(big_grant), .led(big_led), .busy(big_busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  led;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] led;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [31:0] D0 = 32'h44332211;
  localparam logic [31:0] D1 = 32'h443322A5;
  localparam logic [31:0] D2 = 32'h4433223C;
  localparam logic [31:0] D3 = 32'h5533223C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g, input logic [7:0] l);
    vec_t v;
    v.req = r; v.data = d; v.grant = g; v.led = l;
    vecs.push_back(v);
  endtask

  task automatic step(input string nm, input logic [3:0] r, input logic [31:0] d,
                      input logic [3:0] g, input logic [7:0] l);
    exp_t e;
    exp_t got;
    @(negedge clk);
    req  = r;
    data = d;
    e.grant = g; e.led = l;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({nm, "_grant"}, 32'(grant), 32'(got.grant));
    chk({nm, "_led"},   32'(led),   32'(got.led));
    chk({nm, "_busy"},  32'(busy),  32'(|got.grant));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    resetn = 1'b0;
    req    = 4'b0000;
    data   = D0;

    // Rotation under full load with a 4-cycle slice, then latency, release and preemption cases.
    add(4'b0000, D0, 4'b0000, 8'hC3);
    for (int i = 0; i < 4; i++) add(4'b1111, D0, 4'b0001, 8'h11);
    for (int i = 0; i < 4; i++) add(4'b1111, D0, 4'b0010, 8'h22);
    for (int i = 0; i < 4; i++) add(4'b1111, D0, 4'b0100, 8'h33);
    for (int i = 0; i < 4; i++) add(4'b1111, D0, 4'b1000, 8'h44);
    add(4'b1111, D0, 4'b0001, 8'h11);
    add(4'b0001, D1, 4'b0001, 8'hA5);
    add(4'b0001, D2, 4'b0001, 8'h3C);
    add(4'b0000, D2, 4'b0000, 8'hC3);
    add(4'b0010, D2, 4'b0010, 8'h22);
    add(4'b1001, D2, 4'b1000, 8'h44);
    add(4'b1000, D3, 4'b1000, 8'h55);
    add(4'b1010, D3, 4'b1000, 8'h55);
    add(4'b1000, D3, 4'b1000, 8'h55);
    add(4'b1000, D3, 4'b1000, 8'h55);
    add(4'b1000, D3, 4'b1000, 8'h55);
    add(4'b1100, D3, 4'b0100, 8'h33);
    add(4'b0000, D3, 4'b0000, 8'hC3);
    add(4'b0000, D3, 4'b0000, 8'hC3);
    add(4'b1000, D3, 4'b1000, 8'h55);
    add(4'b0000, D3, 4'b0000, 8'hC3);
    add(4'b0100, D3, 4'b0100, 8'h33);

    #7;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_led",   32'(led),   32'hC3);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_big_led", 32'(big_led), 32'h00);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].grant, vecs[i].led);
    end

    // Asynchronous reset between edges while client 2 owns the bank.
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_led",   32'(led),   32'hC3);
    chk("async_rst_busy",  32'(busy),  32'h0);
    resetn = 1'b1;
    step("post_rst_first", 4'b1111, D0, 4'b0001, 8'h11);

    // Default-parameter instance: long lone ownership, preemption on saturation, full slice length.
    @(negedge clk);
    resetn = 1'b0;
    req    = 4'b0100;
    data   = D0;
    #1;
    resetn = 1'b1;
    bad = 0;
    repeat (3000) begin
      @(posedge clk);
      #1;
      if (big_grant !== 4'b0100) bad++;
    end
    chk("big_hold_alone", 32'(bad), 32'd0);
    @(negedge clk);
    req = 4'b0101;
    @(posedge clk);
    #1;
    chk("big_preempt_grant", 32'(big_grant), 32'h1);
    chk("big_preempt_led",   32'(big_led),   32'h11);
    bad = 0;
    repeat (1023) begin
      @(posedge clk);
      #1;
      if (big_grant !== 4'b0001) bad++;
    end
    chk("big_slice_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    chk("big_slice_end_grant", 32'(big_grant), 32'h4);
    chk("big_slice_end_led",   32'(big_led),   32'h33);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("big_idle_grant", 32'(big_grant), 32'h0);
    chk("big_idle_led",   32'(big_led),   32'h00);
    chk("big_idle_busy",  32'(big_busy),  32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
